// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - post-add normalise / round-to-nearest-even / IEEE-754 pack stage
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready   upstream handshake; in_ready is high only while idle
//   in_sign, in_exp      sign and signed biased exponent from the adder
//   in_man[27:0]         [27]=carry [26]=hidden [25:3]=fraction [2]=guard [1]=round [0]=sticky
//   out_valid, out_ready downstream handshake; out_valid is high only while holding a result
//   result               packed single-precision word
//   overflow, underflow, inexact  status flags for the held result
module fp_normalize_round #(
    parameter int EXP_W   = 10,
    parameter bit SAT_OVF = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [27:0]      in_man,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             overflow,
    output logic             underflow,
    output logic             inexact
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = EXP_W'(0);
    localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(255);

    state_t                  state, state_nx;
    logic                    sign_q, sign_nx;
    logic signed [EXP_W-1:0] exp_q, exp_nx;
    logic [27:0]             man_q, man_nx;

    logic [31:0]             result_nx;
    logic                    overflow_nx, underflow_nx, inexact_nx;

    // Rounding datapath, evaluated continuously from the working registers
    logic                    rnd_g, rnd_rs, rnd_up;
    logic [27:0]             rnd_sum;
    logic [27:0]             man_r;
    logic signed [EXP_W-1:0] exp_r;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q    <= 1'b0;
            exp_q     <= EXP_ZERO;
            man_q     <= 28'd0;
            result    <= 32'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            sign_q    <= sign_nx;
            exp_q     <= exp_nx;
            man_q     <= man_nx;
            result    <= result_nx;
            overflow  <= overflow_nx;
            underflow <= underflow_nx;
            inexact   <= inexact_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        sign_nx      = sign_q;
        exp_nx       = exp_q;
        man_nx       = man_q;
        result_nx    = result;
        overflow_nx  = overflow;
        underflow_nx = underflow;
        inexact_nx   = inexact;

        // Nearest-even: bump only when guard is set and either something
        // below it is set or the kept LSB is odd.
        rnd_g   = man_q[2];
        rnd_rs  = man_q[1] | man_q[0];
        rnd_up  = rnd_g & (rnd_rs | man_q[3]);
        // man_q[27] is always clear on entry to ROUND, so this cannot wrap.
        rnd_sum = man_q + {24'd0, rnd_up, 3'b000};
        if (rnd_sum[27]) begin
            man_r = {1'b0, rnd_sum[27:1]};
            exp_r = exp_q + EXP_ONE;
        end else begin
            man_r = rnd_sum;
            exp_r = exp_q;
        end

        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    sign_nx  = in_sign;
                    exp_nx   = $signed(in_exp);
                    man_nx   = in_man;
                    state_nx = S_NORM;
                end
            end
            S_NORM: begin
                if (man_q == 28'd0) begin
                    state_nx = S_ROUND;
                end else if (man_q[27]) begin
                    // Carry-out: one right shift, folding the dropped bit into sticky
                    man_nx   = {1'b0, man_q[27:2], man_q[1] | man_q[0]};
                    exp_nx   = exp_q + EXP_ONE;
                    state_nx = S_ROUND;
                end else if (man_q[27:26] == 2'b00 && exp_q > EXP_ONE) begin
                    // Cancellation: one left shift per cycle, never below exp=1
                    man_nx = {man_q[26:0], 1'b0};
                    exp_nx = exp_q - EXP_ONE;
                end else begin
                    state_nx = S_ROUND;
                end
            end
            S_ROUND: begin
                overflow_nx  = 1'b0;
                underflow_nx = 1'b0;
                inexact_nx   = rnd_g | rnd_rs;
                if (man_r == 28'd0) begin
                    result_nx  = {sign_q, 31'd0};
                    inexact_nx = 1'b0;
                end else if (exp_r >= EXP_MAX) begin
                    overflow_nx = 1'b1;
                    inexact_nx  = 1'b1;
                    result_nx   = SAT_OVF ? {sign_q, 31'h7F7FFFFF} : {sign_q, 8'hFF, 23'd0};
                end else if (exp_r <= EXP_ZERO || !man_r[26]) begin
                    // Subnormals are flushed to signed zero
                    underflow_nx = 1'b1;
                    inexact_nx   = 1'b1;
                    result_nx    = {sign_q, 31'd0};
                end else begin
                    result_nx = {sign_q, exp_r[7:0], man_r[25:3]};
                end
                state_nx = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - vector table, corner sequences and randomized model check for fp_normalize_round
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [27:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    int tests = 0;
    int fails = 0;

    fp_normalize_round #(.EXP_W(10), .SAT_OVF(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          s;
        int          e;
        logic [27:0] m;
        logic [31:0] res;
        bit          ovf;
        bit          unf;
        bit          inx;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        bit          ovf;
        bit          unf;
        bit          inx;
        int          lat;
    } exp_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: closed-form shift count, then integer round-to-nearest-even
    function automatic exp_t model(input bit s, input int e, input logic [27:0] m);
        exp_t   r;
        longint mm;
        longint q;
        int     ee;
        int     k;
        int     p;
        bit     g;
        bit     rs;
        mm = longint'(m);
        ee = e;
        k  = 0;
        p  = -1;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        if (p == 27) begin
            mm = (mm >> 1) | (mm & 64'sd1);
            ee = ee + 1;
        end else if (p >= 0 && p < 26 && ee > 1) begin
            k  = (26 - p < ee - 1) ? 26 - p : ee - 1;
            mm = mm << k;
            ee = ee - k;
        end
        q     = mm >>> 3;
        g     = mm[2];
        rs    = (mm & 64'sd3) != 0;
        r.inx = g | rs;
        if (g && (rs || q[0])) q = q + 1;
        if (q >= (64'sd1 <<< 24)) begin
            q  = q >>> 1;
            ee = ee + 1;
        end
        r.lat = k + 2;
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (m == 28'd0) begin
            r.res = {s, 31'd0};
            r.inx = 1'b0;
        end else if (ee >= 255) begin
            r.ovf = 1'b1;
            r.inx = 1'b1;
            r.res = {s, 8'hFF, 23'd0};
        end else if (ee <= 0 || q < (64'sd1 <<< 23)) begin
            r.unf = 1'b1;
            r.inx = 1'b1;
            r.res = {s, 31'd0};
        end else begin
            r.res = {s, ee[7:0], q[22:0]};
        end
        return r;
    endfunction

    task automatic start_op(input bit s, input int e, input logic [27:0] m);
        in_sign  = s;
        in_exp   = e[9:0];
        in_man   = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
            if (out_valid) break;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_op(input string name, input bit s, input int e, input logic [27:0] m,
                          input exp_t x);
        int cnt;
        check({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        start_op(s, e, m);
        wait_valid(cnt);
        if (!out_valid) begin
            check({name, ".timeout"}, {31'd0, out_valid}, 32'd1);
            pulse_reset();
        end else begin
            check({name, ".latency"}, cnt, x.lat);
            check({name, ".result"}, result, x.res);
            check({name, ".overflow"}, {31'd0, overflow}, {31'd0, x.ovf});
            check({name, ".underflow"}, {31'd0, underflow}, {31'd0, x.unf});
            check({name, ".inexact"}, {31'd0, inexact}, {31'd0, x.inx});
            release_out();
        end
    endtask

    initial begin
        exp_t        x;
        int          cnt;
        bit          s;
        int          e;
        logic [27:0] m;
        logic [31:0] held;

        vecs[0]  = '{1'b0, 127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 2};
        vecs[1]  = '{1'b0, 127, 28'h6000004, 32'h3FC00000, 1'b0, 1'b0, 1'b1, 2};
        vecs[2]  = '{1'b0, 127, 28'h0000008, 32'h34000000, 1'b0, 1'b0, 1'b0, 25};
        vecs[3]  = '{1'b0, 254, 28'h7FFFFFC, 32'h7F800000, 1'b1, 1'b0, 1'b1, 2};
        vecs[4]  = '{1'b1, 5,   28'h0000008, 32'h80000000, 1'b0, 1'b1, 1'b1, 6};
        vecs[5]  = '{1'b1, 100, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 2};
        vecs[6]  = '{1'b0, 127, 28'h400000C, 32'h3F800002, 1'b0, 1'b0, 1'b1, 2};
        vecs[7]  = '{1'b0, 127, 28'h4000005, 32'h3F800001, 1'b0, 1'b0, 1'b1, 2};
        vecs[8]  = '{1'b0, 100, 28'hC000003, 32'h32C00000, 1'b0, 1'b0, 1'b1, 2};
        vecs[9]  = '{1'b0, 0,   28'h4000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 2};
        vecs[10] = '{1'b1, 255, 28'h4000000, 32'hFF800000, 1'b1, 1'b0, 1'b1, 2};
        vecs[11] = '{1'b0, 3,   28'h1000000, 32'h00800000, 1'b0, 1'b0, 1'b0, 4};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_man    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);
        check("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check("reset.result", result, 32'd0);
        check("reset.flags", {29'd0, overflow, underflow, inexact}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            x.res = vecs[i].res;
            x.ovf = vecs[i].ovf;
            x.unf = vecs[i].unf;
            x.inx = vecs[i].inx;
            x.lat = vecs[i].lat;
            run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, vecs[i].m, x);
        end

        // Result is not cleared on leaving DONE
        check("hold_after_done", result, vecs[11].res);

        // Backpressure, then an input offered on the release edge must wait a cycle
        start_op(vecs[6].s, vecs[6].e, vecs[6].m);
        wait_valid(cnt);
        check("bp.reach_done", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp.out_valid", {31'd0, out_valid}, 32'd1);
            check("bp.in_ready", {31'd0, in_ready}, 32'd0);
            check("bp.result", result, vecs[6].res);
        end
        in_sign   = vecs[0].s;
        in_exp    = 10'(vecs[0].e);
        in_man    = vecs[0].m;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp.release_valid", {31'd0, out_valid}, 32'd0);
        check("bp.release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp.accepted", {31'd0, in_ready}, 32'd0);
        wait_valid(cnt);
        check("bp.next_latency", cnt, 2);
        check("bp.next_result", result, vecs[0].res);
        release_out();

        // Reset mid-normalisation discards the operation immediately
        start_op(vecs[2].s, vecs[2].e, vecs[2].m);
        repeat (5) @(posedge clk);
        #1;
        check("rst.mid_busy", {30'd0, in_ready, out_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst.async_valid", {31'd0, out_valid}, 32'd0);
        check("rst.async_ready", {31'd0, in_ready}, 32'd1);
        check("rst.result_clr", result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        x   = model(vecs[1].s, vecs[1].e, vecs[1].m);
        run_op("rst.recover", vecs[1].s, vecs[1].e, vecs[1].m, x);

        // Randomized operands against the reference model
        for (int i = 0; i < 150; i++) begin
            s = 1'($urandom_range(0, 1));
            e = int'($urandom_range(0, 280)) - 10;
            m = 28'($urandom) >> $urandom_range(0, 27);
            if ($urandom_range(0, 15) == 0) m = 28'd0;
            x = model(s, e, m);
            run_op($sformatf("rnd%0d", i), s, e, m, x);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
